mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the coprocessor's single-port 16-bit scratch memory controller (`memory_mod` handshake: `start`/`wr`/`done`).
- Accepts independent read/write requests from two clients, typically the instruction loader (port 0) and the matrix ALU (port 1).
- Grants one client at a time with round-robin fairness, drives the memory handshake, and returns read data with a per-client acknowledge.
- Adds a timeout so a missing `done` cannot hang the coprocessor.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: round-robin arbiter between two scratch-memory clients.
// Latches the winning request, runs the start/wr/done handshake with the
// memory controller, and returns an ack (with optional timeout error) to
// the client that was served.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              grant,
  output logic              mem_start,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

  state_t              state, state_d;
  logic                win;
  logic                last_q;
  logic                grant_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [7:0]          cnt_q;
  logic                err_q;

  // Winner selection: a lone request wins; on a tie the port not served last wins.
  assign win = (req0 && req1) ? ~last_q : req1;

  // State register; async reset puts the FSM in IDLE so mem_start/mem_wr drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state;
    case (state)
      S_IDLE:    if (req0 || req1) state_d = S_ISSUE;
      S_ISSUE:   if (mem_done || (cnt_q == TIMEOUT_VAL)) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request latch, timeout counter, read capture and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too because mem_addr, mem_wdata and
    // rdata are visible outputs that must read 0 after reset.
    if (!rst_n) begin
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_q <= '0;
          if (req0 || req1) begin
            grant_q <= win;
            wr_q    <= win ? wr1    : wr0;
            addr_q  <= win ? addr1  : addr0;
            wdata_q <= win ? wdata1 : wdata0;
          end
        end
        S_ISSUE: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_done) begin
            if (!wr_q) rdata_q <= mem_rdata;
            err_q <= 1'b0;
          end else if (cnt_q == TIMEOUT_VAL) begin
            err_q <= 1'b1;
          end
        end
        S_RELEASE: last_q <= grant_q;
        default: ;
      endcase
    end
  end

  // Handshake and client outputs decoded from state and latched request.
  assign mem_start = (state == S_ISSUE);
  assign mem_wr    = (state == S_ISSUE) && wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != S_IDLE);
  assign grant     = grant_q;
  assign ack0      = (state == S_RELEASE) && !grant_q;
  assign ack1      = (state == S_RELEASE) &&  grant_q;
  assign err       = (state == S_RELEASE) && err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter: memory controller model, table of
// directed transactions, hand-written multi-cycle sequences and a random
// phase checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err, busy, grant;
  logic          mem_start, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;
  logic          mem_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy), .grant(grant),
    .mem_start(mem_start), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  // Memory controller model: read done after 1 start cycle, write after 4.
  logic [DW-1:0] ram [256];
  logic [2:0]    mcnt = '0;
  logic          mem_hang = 1'b0;
  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_start) begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      if (mcnt != 3'd7) mcnt <= mcnt + 3'd1;
      mem_done <= mem_done || (!mem_hang && (mem_wr ? (mcnt == 3'd3) : 1'b1));
    end else begin
      mcnt     <= '0;
      mem_done <= 1'b0;
    end
  end

  // Reference model state: shadow memory, last-served port, held read data.
  logic [DW-1:0] shadow [256];
  logic          m_last;
  logic [DW-1:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts the served port and its result from the arbitration rules.
  task automatic model_step(input logic r0, input logic r1, input logic w0, input logic w1,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            output logic g, output logic [DW-1:0] rd, output int lat);
    logic          w;
    logic [AW-1:0] a;
    if (r0 && r1) g = ~m_last;
    else          g = r1;
    w   = g ? w1 : w0;
    a   = g ? a1 : a0;
    lat = w ? 6 : 3;
    if (w) shadow[a] = g ? d1 : d0;
    else   m_rdata   = shadow[a];
    rd     = m_rdata;
    m_last = g;
  endtask

  // Applies one request set in an IDLE cycle, waits for the ack, checks it,
  // and drops the requests during the ack cycle.
  task automatic run_txn(input string name, input logic r0, input logic r1,
                         input logic w0, input logic w1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic exp_g, input logic [DW-1:0] exp_rd,
                         input int exp_lat, input logic exp_err);
    int   lat;
    logic saw_wr, stray_err;
    @(posedge clk); #1;
    req0 = r0; req1 = r1; wr0 = w0; wr1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    lat = 0; saw_wr = 0; stray_err = 0;
    forever begin
      @(negedge clk);
      if (mem_wr) saw_wr = 1;
      if (ack0 || ack1 || lat > 100) break;
      if (err) stray_err = 1;
      lat++;
    end
    req0 = 0; req1 = 0;
    check({name, "_no_timeout"}, 32'(lat <= 100), 32'd1);
    check({name, "_ack"},   {30'd0, ack1, ack0}, exp_g ? 32'd2 : 32'd1);
    check({name, "_grant"}, 32'(grant), 32'(exp_g));
    check({name, "_rdata"}, 32'(rdata), 32'(exp_rd));
    check({name, "_err"},   32'(err), 32'(exp_err));
    check({name, "_lat"},   32'(lat), 32'(exp_lat));
    check({name, "_memwr"}, 32'(saw_wr), 32'(exp_g ? w1 : w0));
    check({name, "_err_only_in_ack"}, 32'(stray_err), 32'd0);
  endtask

  typedef struct {
    logic          r0, r1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          exp_g;
    logic [DW-1:0] exp_rd;
    int            exp_lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic          g;
    logic [DW-1:0] rd;
    int            lat;
    int            acks;

    for (int i = 0; i < 256; i++) begin
      ram[i]    = 16'(i * 257) ^ 16'hA5A5;
      shadow[i] = ram[i];
    end
    ram[8'h10] = 16'hBEEF; shadow[8'h10] = 16'hBEEF;
    ram[8'h11] = 16'hCAFE; shadow[8'h11] = 16'hCAFE;
    m_last = 1'b1; m_rdata = '0;

    vecs[0] = '{1,0, 0,0, 8'h10,8'h00, 16'h0,16'h0,    0, 16'hBEEF, 3};
    vecs[1] = '{0,1, 0,1, 8'h00,8'h22, 16'h0,16'h1234, 1, 16'hBEEF, 6};
    vecs[2] = '{0,1, 0,0, 8'h00,8'h22, 16'h0,16'h0,    1, 16'h1234, 3};
    vecs[3] = '{1,1, 1,0, 8'h30,8'h10, 16'h5555,16'h0, 0, 16'h1234, 6};
    vecs[4] = '{1,1, 0,0, 8'h30,8'h22, 16'h0,16'h0,    1, 16'h1234, 3};
    vecs[5] = '{1,1, 0,1, 8'h30,8'h40, 16'h0,16'h7777, 0, 16'h5555, 3};
    vecs[6] = '{1,0, 0,0, 8'h30,8'h00, 16'h0,16'h0,    0, 16'h5555, 3};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   {30'd0, ack1, ack0}, 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_mem",   {30'd0, mem_start, mem_wr}, 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_mwdata", 32'(mem_wdata), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Both requests held over four transactions: grants alternate from port 0.
    @(posedge clk); #1;
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0; addr0 = 8'h10; addr1 = 8'h11;
    acks = 0;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        check("tie_port",  {30'd0, ack1, ack0}, (acks % 2 == 1) ? 32'd2 : 32'd1);
        check("tie_rdata", 32'(rdata), (acks % 2 == 1) ? 32'hCAFE : 32'hBEEF);
        acks++;
      end
    end
    req0 = 0; req1 = 0;
    check("tie_count", 32'(acks), 32'd4);
    m_last = 1'b1; m_rdata = 16'hCAFE;

    // Directed table.
    foreach (vecs[i]) begin
      model_step(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, vecs[i].a0, vecs[i].a1,
                 vecs[i].d0, vecs[i].d1, g, rd, lat);
      run_txn($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
              vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1,
              vecs[i].exp_g, vecs[i].exp_rd, vecs[i].exp_lat, 1'b0);
    end

    // Back-to-back reads on port 0: mem_start low exactly 2 cycles between accesses.
    begin
      int   low_run;
      logic seen_high, prev_ack;
      @(posedge clk); #1;
      req0 = 1; wr0 = 0; addr0 = 8'h10;
      acks = 0; low_run = 0; seen_high = 0; prev_ack = 0;
      for (int c = 0; c < 60 && acks < 3; c++) begin
        @(negedge clk);
        if (mem_start) begin
          if (seen_high && low_run > 0) check("b2b_gap", 32'(low_run), 32'd2);
          low_run = 0; seen_high = 1;
        end else begin
          low_run++;
        end
        if (ack0) begin
          check("b2b_ack_single", 32'(prev_ack), 32'd0);
          check("b2b_rdata", 32'(rdata), 32'hBEEF);
          acks++;
        end
        prev_ack = ack0;
      end
      req0 = 0;
      check("b2b_count", 32'(acks), 32'd3);
      m_last = 1'b0; m_rdata = shadow[8'h10];
    end

    // Timeout: memory never answers; rdata must be held.
    mem_hang = 1'b1;
    run_txn("timeout", 1, 0, 0, 0, 8'h22, 8'h00, 16'h0, 16'h0, 0, m_rdata, TO + 2, 1'b1);
    mem_hang = 1'b0;
    m_last = 1'b0;
    model_step(0, 1, 0, 0, 8'h00, 8'h22, 16'h0, 16'h0, g, rd, lat);
    run_txn("after_timeout", 0, 1, 0, 0, 8'h00, 8'h22, 16'h0, 16'h0, g, rd, lat, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]    r;
      logic          w0r, w1r;
      logic [AW-1:0] a0r, a1r;
      logic [DW-1:0] d0r, d1r;
      r   = 2'($urandom_range(1, 3));
      w0r = 1'($urandom); w1r = 1'($urandom);
      a0r = 8'($urandom_range(0, 15)); a1r = 8'($urandom_range(0, 15));
      d0r = 16'($urandom); d1r = 16'($urandom);
      model_step(r[0], r[1], w0r, w1r, a0r, a1r, d0r, d1r, g, rd, lat);
      run_txn($sformatf("rnd%0d", i), r[0], r[1], w0r, w1r, a0r, a1r, d0r, d1r,
              g, rd, lat, 1'b0);
    end

    // Reset two cycles into a write ISSUE.
    @(posedge clk); #1;
    req1 = 1; wr1 = 1; addr1 = 8'h50; wdata1 = 16'hDEAD;
    @(posedge clk);
    @(posedge clk); #1;
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_drop", {30'd0, mem_start, mem_wr}, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    req1 = 0; wr1 = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    check("midrst_no_ack", 32'(acks), 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    m_last = 1'b1; m_rdata = '0;
    model_step(1, 1, 0, 0, 8'h10, 8'h22, 16'h0, 16'h0, g, rd, lat);
    run_txn("after_rst", 1, 1, 0, 0, 8'h10, 8'h22, 16'h0, 16'h0, g, rd, lat, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
